// File: rtl/holy_clint.sv
// holy_clint: machine-level CLINT with a prescaled 64-bit mtime, mtimecmp and msip on a valid/ready bus.
// Optional HOLY_CLINT_MTIME_LATCH_EN: a read of mtime lo latches mtime hi for an atomic lo-then-hi pair.
module holy_clint #(
   parameter int unsigned TICK_DIV = 1,
   parameter int unsigned ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_strb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              timer_itr,
   output logic              soft_itr
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [ADDR_W-1:0] ADDR_MSIP     = ADDR_W'(32'h0000_0000);
   localparam logic [ADDR_W-1:0] ADDR_CMP_LO   = ADDR_W'(32'h0000_4000);
   localparam logic [ADDR_W-1:0] ADDR_CMP_HI   = ADDR_W'(32'h0000_4004);
   localparam logic [ADDR_W-1:0] ADDR_MTIME_LO = ADDR_W'(32'h0000_BFF8);
   localparam logic [ADDR_W-1:0] ADDR_MTIME_HI = ADDR_W'(32'h0000_BFFC);

   logic [PW-1:0] presc_q, presc_d;
   logic          tick;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   cmp_q, cmp_d;
   logic          msip_q, msip_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          timer_q, timer_d;
   logic          soft_q, soft_d;
   logic          accept, wr_en, rd_en;
   logic [31:0]   rdata;

`ifdef HOLY_CLINT_MTIME_LATCH_EN
   logic [31:0]   shadow_q, shadow_d;
   logic          latched_q, latched_d;
`endif

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
      end
      return res;
   endfunction

   assign req_ready = ~rsp_valid_q | rsp_ready;
   assign accept    = req_valid & req_ready;
   // A write with no byte enables is a pure no-op so it cannot suppress a tick.
   assign wr_en     = accept & req_write & (|req_strb);
   assign rd_en     = accept & ~req_write;

   always_comb begin
      tick    = (presc_q == PW'(TICK_DIV - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

   always_comb begin
      rdata = '0;
      case (req_addr)
         ADDR_MSIP:     rdata = {31'd0, msip_q};
         ADDR_CMP_LO:   rdata = cmp_q[31:0];
         ADDR_CMP_HI:   rdata = cmp_q[63:32];
         ADDR_MTIME_LO: rdata = mtime_q[31:0];
         ADDR_MTIME_HI: begin
`ifdef HOLY_CLINT_MTIME_LATCH_EN
            rdata = latched_q ? shadow_q : mtime_q[63:32];
`else
            rdata = mtime_q[63:32];
`endif
         end
         default:       rdata = '0;
      endcase
   end

   always_comb begin
      mtime_d = mtime_q;
      cmp_d   = cmp_q;
      msip_d  = msip_q;
      // Bus writes to mtime win over the tick; the increment is dropped that cycle.
      if (wr_en && (req_addr == ADDR_MTIME_LO)) begin
         mtime_d[31:0] = merge_bytes(mtime_q[31:0], req_wdata, req_strb);
      end else if (wr_en && (req_addr == ADDR_MTIME_HI)) begin
         mtime_d[63:32] = merge_bytes(mtime_q[63:32], req_wdata, req_strb);
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
      if (wr_en && (req_addr == ADDR_CMP_LO)) begin
         cmp_d[31:0] = merge_bytes(cmp_q[31:0], req_wdata, req_strb);
      end
      if (wr_en && (req_addr == ADDR_CMP_HI)) begin
         cmp_d[63:32] = merge_bytes(cmp_q[63:32], req_wdata, req_strb);
      end
      if (wr_en && (req_addr == ADDR_MSIP) && req_strb[0]) begin
         msip_d = req_wdata[0];
      end
      timer_d = (mtime_d >= cmp_d);
      soft_d  = msip_d;
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = req_write ? 32'd0 : rdata;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

`ifdef HOLY_CLINT_MTIME_LATCH_EN
   always_comb begin
      shadow_d  = shadow_q;
      latched_d = latched_q;
      if (rd_en && (req_addr == ADDR_MTIME_LO)) begin
         shadow_d  = mtime_q[63:32];
         latched_d = 1'b1;
      end else if (rd_en && (req_addr == ADDR_MTIME_HI)) begin
         latched_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q  <= '0;
         latched_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         latched_q <= latched_d;
      end
   end
`else
   logic unused_rd_en;
   assign unused_rd_en = rd_en;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         mtime_q     <= '0;
         cmp_q       <= '1;
         msip_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         timer_q     <= 1'b0;
         soft_q      <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         mtime_q     <= mtime_d;
         cmp_q       <= cmp_d;
         msip_q      <= msip_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         timer_q     <= timer_d;
         soft_q      <= soft_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign timer_itr = timer_q;
   assign soft_itr  = soft_q;

endmodule

// File: tb/tb_holy_clint.sv
// Self-checking bench for holy_clint: directed scenarios plus randomized bus traffic against a model.
// Honors HOLY_CLINT_MTIME_LATCH_EN for the atomic mtime read expectations.
module tb_holy_clint;

   localparam int unsigned TB_TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_strb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        timer_itr;
   logic        soft_itr;

   int n_tests = 0;
   int n_fail  = 0;

   holy_clint #(.TICK_DIV(TB_TICK_DIV), .ADDR_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_strb  (req_strb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .timer_itr (timer_itr),
      .soft_itr  (soft_itr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: architectural state advanced once per clock from the observed bus inputs.
   logic [63:0] m_mtime, m_cmp, n_mtime, n_cmp;
   logic        m_msip, n_msip, m_rsp_valid, n_rsp_valid, m_timer, m_soft;
   logic [31:0] m_rdata, n_rdata, m_shadow, n_shadow;
   logic        m_latched, n_latched;
   int unsigned m_cyc;
   logic        m_acc, m_wr, m_tick;

   function automatic logic [31:0] put_bytes(input logic [31:0] v, input logic [31:0] d,
                                             input logic [3:0] s);
      logic [31:0] r;
      r = v;
      for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   always_comb begin
      m_acc       = req_valid && (!m_rsp_valid || rsp_ready);
      m_wr        = m_acc && req_write && (req_strb != 4'd0);
      m_tick      = (m_cyc % TB_TICK_DIV) == (TB_TICK_DIV - 1);
      n_mtime     = m_tick ? m_mtime + 64'd1 : m_mtime;
      n_cmp       = m_cmp;
      n_msip      = m_msip;
      n_shadow    = m_shadow;
      n_latched   = m_latched;
      n_rsp_valid = m_rsp_valid;
      n_rdata     = m_rdata;
      if (m_wr) begin
         case (req_addr)
            16'hBFF8: n_mtime = {m_mtime[63:32], put_bytes(m_mtime[31:0], req_wdata, req_strb)};
            16'hBFFC: n_mtime = {put_bytes(m_mtime[63:32], req_wdata, req_strb), m_mtime[31:0]};
            16'h4000: n_cmp = {m_cmp[63:32], put_bytes(m_cmp[31:0], req_wdata, req_strb)};
            16'h4004: n_cmp = {put_bytes(m_cmp[63:32], req_wdata, req_strb), m_cmp[31:0]};
            16'h0000: if (req_strb[0]) n_msip = req_wdata[0];
            default: ;
         endcase
      end
      if (m_acc) begin
         n_rsp_valid = 1'b1;
         n_rdata     = 32'd0;
         if (!req_write) begin
            case (req_addr)
               16'h0000: n_rdata = {31'd0, m_msip};
               16'h4000: n_rdata = m_cmp[31:0];
               16'h4004: n_rdata = m_cmp[63:32];
               16'hBFF8: begin
                  n_rdata   = m_mtime[31:0];
                  n_shadow  = m_mtime[63:32];
                  n_latched = 1'b1;
               end
               16'hBFFC: begin
`ifdef HOLY_CLINT_MTIME_LATCH_EN
                  n_rdata = m_latched ? m_shadow : m_mtime[63:32];
`else
                  n_rdata = m_mtime[63:32];
`endif
                  n_latched = 1'b0;
               end
               default: n_rdata = 32'd0;
            endcase
         end
      end else if (rsp_ready) begin
         n_rsp_valid = 1'b0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc <= 0; m_mtime <= '0; m_cmp <= '1; m_msip <= 1'b0;
         m_rsp_valid <= 1'b0; m_rdata <= '0; m_timer <= 1'b0; m_soft <= 1'b0;
         m_shadow <= '0; m_latched <= 1'b0;
      end else begin
         m_cyc <= m_cyc + 1;
         m_mtime <= n_mtime; m_cmp <= n_cmp; m_msip <= n_msip;
         m_rsp_valid <= n_rsp_valid; m_rdata <= n_rdata;
         m_timer <= (n_mtime >= n_cmp); m_soft <= n_msip;
         m_shadow <= n_shadow; m_latched <= n_latched;
      end
   end

   // Cycle-by-cycle comparison mid-cycle, well away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_rsp_valid});
         check("req_ready", {63'd0, req_ready}, {63'd0, (!m_rsp_valid || rsp_ready)});
         check("timer_itr", {63'd0, timer_itr}, {63'd0, m_timer});
         check("soft_itr", {63'd0, soft_itr}, {63'd0, m_soft});
         if (m_rsp_valid) check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, m_rdata});
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accept edge with the response visible.
   task automatic bus(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, output logic [31:0] rd);
      logic acc;
      int   n;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_strb = strb;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         #1;
         acc = req_ready;
         @(posedge clk);
         #1;
         n++;
      end
      req_valid = 1'b0;
      if (!acc) check("bus_accept_timeout", 64'd0, 64'd1);
      rd = rsp_rdata;
   endtask

   logic [31:0] rd;
   logic [31:0] hold_rd;
   logic [15:0] addrs [7];
   int          waited;

   initial begin
      addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1234, 16'h4002};

      #3;
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
      check("rst_timer", {63'd0, timer_itr}, 64'd0);
      check("rst_soft", {63'd0, soft_itr}, 64'd0);
      #9 rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      bus(1'b0, 16'hBFF8, 32'd0, 4'h0, rd);
      check("mtime_after_40", {63'd0, (rd >= 32'd9 && rd <= 32'd11)}, 64'd1);
      check("idle_timer", {63'd0, timer_itr}, 64'd0);
      check("idle_soft", {63'd0, soft_itr}, 64'd0);
      bus(1'b0, 16'h4000, 32'd0, 4'h0, rd);
      check("cmp_lo_rst", {32'd0, rd}, 64'hFFFF_FFFF);
      bus(1'b0, 16'h4004, 32'd0, 4'h0, rd);
      check("cmp_hi_rst", {32'd0, rd}, 64'hFFFF_FFFF);

      bus(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, rd);
      check("msip_set_soft", {63'd0, soft_itr}, 64'd1);
      bus(1'b0, 16'h0000, 32'd0, 4'h0, rd);
      check("msip_readback", {32'd0, rd}, 64'd1);
      bus(1'b1, 16'h0000, 32'd0, 4'hF, rd);
      check("msip_clr_soft", {63'd0, soft_itr}, 64'd0);

      bus(1'b1, 16'h4004, 32'd0, 4'hF, rd);
      bus(1'b1, 16'h4000, 32'd20, 4'hF, rd);
      waited = 0;
      while (!timer_itr && waited < 200) begin
         idle(1);
         waited++;
      end
      if (waited >= 200) check("timer_rise_timeout", 64'd0, 64'd1);
      bus(1'b0, 16'hBFF8, 32'd0, 4'h0, rd);
      check("mtime_at_itr", {63'd0, (rd >= 32'd20 && rd <= 32'd22)}, 64'd1);
      bus(1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF, rd);
      check("timer_fall", {63'd0, timer_itr}, 64'd0);

      // Write then read back at every prescaler phase: a coinciding tick must not add one.
      for (int i = 0; i < 8; i++) begin
         idle(i);
         bus(1'b1, 16'hBFF8, 32'd100, 4'hF, rd);
         bus(1'b0, 16'hBFF8, 32'd0, 4'h0, rd);
         check("wr_beats_tick", {32'd0, rd}, 64'd100);
      end

      bus(1'b1, 16'hBFFC, 32'd0, 4'hF, rd);
      bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd);
      bus(1'b0, 16'hBFF8, 32'd0, 4'h0, rd);
      check("carry_lo_pre", {32'd0, rd}, 64'hFFFF_FFFF);
      idle(5);
      bus(1'b0, 16'hBFFC, 32'd0, 4'h0, rd);
`ifdef HOLY_CLINT_MTIME_LATCH_EN
      check("latched_hi", {32'd0, rd}, 64'd0);
`else
      check("live_hi", {32'd0, rd}, 64'd1);
`endif
      bus(1'b0, 16'hBFFC, 32'd0, 4'h0, rd);
      check("carry_hi", {32'd0, rd}, 64'd1);

      // Stall the response for five cycles with a second request queued behind it.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hBFF8; req_strb = 4'h0;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      req_addr  = 16'h1234;
      hold_rd   = m_rdata;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("hold_req_ready", {63'd0, req_ready}, 64'd0);
         check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
         check("hold_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, hold_rd});
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("queued_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("unmapped_rd", {32'd0, rsp_rdata}, 64'd0);
      idle(2);

      for (int c = 0; c < 600; c++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_write = $urandom_range(0, 1) == 1;
         req_addr  = addrs[$urandom_range(0, 6)];
         req_wdata = (req_addr == 16'hBFFC || req_addr == 16'h4004) ?
                     32'($urandom_range(0, 1)) : $urandom;
         req_strb  = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         idle(1);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      idle(2);

      // Asynchronous reset with a response pending: it must vanish and not reappear.
      bus(1'b1, 16'h0000, 32'd1, 4'h1, rd);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4000;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("pre_rst_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("async_rst_rdata", {32'd0, rsp_rdata}, 64'd0);
      check("async_rst_soft", {63'd0, soft_itr}, 64'd0);
      check("async_rst_timer", {63'd0, timer_itr}, 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      idle(3);
      check("no_rsp_after_rst", {63'd0, rsp_valid}, 64'd0);
      bus(1'b0, 16'h4004, 32'd0, 4'h0, rd);
      check("cmp_hi_after_rst", {32'd0, rd}, 64'hFFFF_FFFF);

      for (int c = 0; c < 200; c++) begin
         req_valid = $urandom_range(0, 1) == 1;
         req_write = $urandom_range(0, 1) == 1;
         req_addr  = addrs[$urandom_range(0, 6)];
         req_wdata = $urandom;
         req_strb  = 4'($urandom_range(0, 15));
         rsp_ready = $urandom_range(0, 1) == 1;
         idle(1);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
